// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle controller for the core's control path.
// Latches each fetched word, decodes the opcode, sequences ALU and data
// memory strobes, and tells the program counter when to hold, step or jump.
// The PC is released (pc_hold=0) in exactly one commit cycle per instruction.

module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W+3:0] instr,
    input  logic              stall,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              mem_ready,
    input  logic              resume,
    output logic              pc_hold,
    output logic              jump_en,
    output logic [ADDR_W-1:0] jump_line_num,
    output logic              ir_load,
    output logic [ADDR_W-1:0] operand,
    output logic              alu_en,
    output logic              reg_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic              halted,
    output logic              fault
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_JZ    = 4'd5;
    localparam logic [3:0] OP_JC    = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Counter holds the number of MEM cycles already spent without mem_ready,
    // so the access gives up on the MEM_TIMEOUT-th cycle.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W+3:0] ir;
    logic [7:0]        tmo_cnt;
    logic [7:0]        tmo_cnt_nxt;
    logic              fault_set;
    logic [3:0]        opcode;
    logic              illegal_op;

    assign opcode     = ir[ADDR_W+3:ADDR_W];
    assign operand    = ir[ADDR_W-1:0];
    assign illegal_op = (opcode >= 4'd7) && (opcode <= 4'd14);

    // State, instruction register, memory timeout counter and sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            tmo_cnt <= '0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            if (ir_load) begin
                ir <= instr;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; the PC is held unless this is a commit cycle.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = '0;
        fault_set   = 1'b0;
        pc_hold     = 1'b1;
        jump_en     = 1'b0;
        ir_load     = 1'b0;
        alu_en      = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;

        case (state)
            S_FETCH: begin
                if (!stall) begin
                    // Gated by rst_n so no load strobe is visible while in reset.
                    ir_load   = rst_n;
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                fault_set = illegal_op;
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                pc_hold   = 1'b0;
                state_nxt = S_FETCH;
                case (opcode)
                    OP_ALU: begin
                        alu_en = 1'b1;
                        reg_we = 1'b1;
                    end
                    OP_JMP:  jump_en = 1'b1;
                    OP_JZ:   jump_en = zero_flag;
                    OP_JC:   jump_en = carry_flag;
                    OP_NOP:  jump_en = 1'b0;
                    default: jump_en = 1'b0;
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ready) begin
                    // A ready on the final allowed cycle still wins over the timeout.
                    pc_hold   = 1'b0;
                    reg_we    = (opcode == OP_LOAD);
                    state_nxt = S_FETCH;
                end else if (tmo_cnt == TMO_LAST) begin
                    fault_set = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end

            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    // Step past the HALT (or the abandoned access) on the way out.
                    pc_hold   = 1'b0;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign jump_line_num = jump_en ? operand : '0;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-cycle controller that drives the 8-bit program counter's `hold`, `jump_en` and `jump_line_num` inputs.
- Latches each fetched instruction, decodes its opcode, and sequences the ALU and data-memory strobes.
- Advances or redirects the PC exactly once per retired instruction.
- Sits between instruction memory, PC, register file and data memory in the core's control path.

Parameters:
- ADDR_W, 8, width of PC / jump target / operand field
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before fault (range 1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  4+ADDR_W  fetched word: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand
- stall  input  1  instruction memory not valid; blocks fetch
- zero_flag  input  1  ALU zero flag
- carry_flag  input  1  ALU carry flag
- mem_ready  input  1  data memory completes the current access
- resume  input  1  single-cycle pulse; leaves HALT
- pc_hold  output  1  to PC hold; 1 = PC keeps its value
- jump_en  output  1  to PC jump_en
- jump_line_num  output  ADDR_W  to PC jump target
- ir_load  output  1  instruction latched this cycle
- operand  output  ADDR_W  latched operand field
- alu_en  output  1  ALU op strobe
- reg_we  output  1  register file write enable
- mem_req  output  1  data memory request
- mem_we  output  1  1 = store, 0 = load (valid while mem_req)
- halted  output  1  in HALT state
- fault  output  1  sticky: illegal opcode or memory timeout

Behaviour:
- Reset: rst_n low forces, asynchronously, the following.
  - state = FETCH; IR = 0; timeout counter = 0; fault = 0.
  - Outputs: pc_hold=1, jump_en=0, jump_line_num=0, ir_load=0, operand=0, alu_en=0, reg_we=0, mem_req=0, mem_we=0, halted=0.
  - Reset mid-instruction abandons it; no strobe survives reset.
- Output timing: outputs are Moore/Mealy decode of state, IR, zero_flag, carry_flag and mem_ready.
  - pc_hold=1 in every cycle except the single commit cycle of an instruction.
  - jump_en, when asserted, always has pc_hold=0.
  - jump_line_num = operand while jump_en=1, else 0.
- Opcodes:
  - 0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 JMP, 5 JZ, 6 JC, 15 HALT.
  - 7-14 are illegal: set fault and execute as NOP.
- States:
  - FETCH: if stall=1, remain and drive ir_load=0. Else ir_load=1, IR <= instr, go DECODE.
  - DECODE: all strobes 0. Next state is HALT if opcode 15, MEM if opcode 2 or 3, otherwise EXEC.
  - EXEC (commit cycle, 1 cycle, then FETCH):
    - NOP / illegal: pc_hold=0.
    - ALU: alu_en=1, reg_we=1, pc_hold=0.
    - JMP: jump_en=1, pc_hold=0.
    - JZ: jump_en=zero_flag, pc_hold=0.
    - JC: jump_en=carry_flag, pc_hold=0.
  - MEM:
    - Outputs: mem_req=1; mem_we=1 for STORE, 0 for LOAD; timeout counter increments each cycle.
    - If mem_ready=1: commit that same cycle. pc_hold=0; reg_we=1 for LOAD; counter cleared; go FETCH.
    - If the counter reaches MEM_TIMEOUT with mem_ready still 0: drop mem_req, set fault, go HALT. The PC does not advance.
  - HALT:
    - Outputs: halted=1, pc_hold=1.
    - On resume=1: pc_hold=0 for that cycle, so the PC steps past the HALT instruction, then go FETCH.
    - resume in any other state is ignored.
    - A timeout-induced HALT resumes the same way; the PC then skips the faulted access.
- Latency:
  - NOP/ALU/jump: 3 cycles (FETCH, DECODE, EXEC) with no stall.
  - Memory op: 2 + n cycles, where n ≥ 1 is the number of MEM cycles up to and including mem_ready.
- Simultaneous events:
  - mem_ready on the same cycle the counter hits MEM_TIMEOUT counts as success.
  - stall is sampled only in FETCH.
  - zero_flag and carry_flag are sampled only in EXEC.
- fault clears only on reset.
- Invariant: at most one of {pc_hold=0 without jump_en, jump_en=1} per instruction; the bench checks that the PC changes exactly once per retired instruction.

Test Plan:
- Reset, then stall=0, instr={1,0x00} repeated → ir_load at cycles 0, 3, 6; pc_hold=0 only at cycles 2, 5, 8; alu_en and reg_we high only at cycles 2, 5, 8; PC reaches 3 after cycle 8.
- instr={5,0x40} with zero_flag=1 at EXEC → jump_en=1, jump_line_num=0x40, PC=0x40. Repeat with zero_flag=0 → jump_en=0, PC+1.
- LOAD with mem_ready asserted on the 3rd MEM cycle → mem_req high 3 cycles, mem_we=0, reg_we=1 and pc_hold=0 on that cycle only, total 5 cycles.
- STORE with mem_ready never asserted, MEM_TIMEOUT=15 → mem_req drops after 15 cycles, fault=1, halted=1, PC unchanged. Pulse resume → PC+1, FETCH resumes, fault stays 1.
- Opcode 15 → halted=1 indefinitely with pc_hold=1. resume pulse → PC+1 and next fetch. Opcode 9 → fault=1, behaves as NOP.
- Assert rst_n=0 in the middle of the MEM state with mem_req=1 → mem_req, reg_we and halted drop immediately (asynchronously), pc_hold=1. After release, a fetch occurs on the first clock with stall=0.
